// File: rtl/hall_pkg.sv
// Shared Hall-sensor definitions for the period meter: legal code constants,
// commutation-order lookups and the measurement FSM state type.
package hall_pkg;

  localparam logic [2:0] HALL_ILL0 = 3'b000;
  localparam logic [2:0] HALL_1    = 3'b001;
  localparam logic [2:0] HALL_2    = 3'b011;
  localparam logic [2:0] HALL_3    = 3'b010;
  localparam logic [2:0] HALL_4    = 3'b110;
  localparam logic [2:0] HALL_5    = 3'b100;
  localparam logic [2:0] HALL_6    = 3'b101;
  localparam logic [2:0] HALL_ILL7 = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    STALL   = 2'd3
  } meter_state_t;

  // Next code when rotating forward; illegal inputs map to HALL_ILL0.
  function automatic logic [2:0] fwd_next(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      HALL_1:  nxt = HALL_2;
      HALL_2:  nxt = HALL_3;
      HALL_3:  nxt = HALL_4;
      HALL_4:  nxt = HALL_5;
      HALL_5:  nxt = HALL_6;
      HALL_6:  nxt = HALL_1;
      default: nxt = HALL_ILL0;
    endcase
    return nxt;
  endfunction

  // Next code when rotating in reverse; illegal inputs map to HALL_ILL0.
  function automatic logic [2:0] rev_next(input logic [2:0] code);
    logic [2:0] nxt;
    case (code)
      HALL_1:  nxt = HALL_6;
      HALL_6:  nxt = HALL_5;
      HALL_5:  nxt = HALL_4;
      HALL_4:  nxt = HALL_3;
      HALL_3:  nxt = HALL_2;
      HALL_2:  nxt = HALL_1;
      default: nxt = HALL_ILL0;
    endcase
    return nxt;
  endfunction

  function automatic logic is_illegal(input logic [2:0] code);
    return (code == HALL_ILL0) || (code == HALL_ILL7);
  endfunction

endpackage

// File: rtl/hall_debouncer.sv
// Hall input conditioning: 2-flop synchroniser followed by a stability filter.
// Ports:
//   clk, reset      - clock, synchronous active-low reset
//   hall[2:0]       - raw asynchronous Hall lines {C,B,A}
//   accepted_code   - last legal code that stayed stable DEBOUNCE_CYCLES cycles
//   accept_strobe   - one-cycle pulse when accepted_code takes a new value
//   illegal_strobe  - one-cycle pulse when 000/111 stays stable DEBOUNCE_CYCLES
module hall_debouncer
  import hall_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] hall,
  output logic [2:0] accepted_code,
  output logic       accept_strobe,
  output logic       illegal_strobe
);

  localparam int unsigned CW = 8;

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    sync_d;
  logic [CW-1:0] stab_cnt;
  logic [CW-1:0] cnt_next;
  logic          held;
  logic          restart;
  logic          fire;

  // A change of the synchronised code restarts the count at its first stable
  // cycle; the count parks at DEBOUNCE_CYCLES so an illegal code fires once.
  always_comb begin
    restart  = (sync2 != sync_d);
    cnt_next = stab_cnt;
    if (restart) begin
      cnt_next = CW'(1);
    end else if (stab_cnt != CW'(DEBOUNCE_CYCLES)) begin
      cnt_next = stab_cnt + CW'(1);
    end
    fire = (sync2 != accepted_code) &&
           (cnt_next == CW'(DEBOUNCE_CYCLES)) &&
           (restart || !held);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1          <= 3'b000;
      sync2          <= 3'b000;
      sync_d         <= 3'b000;
      stab_cnt       <= '0;
      held           <= 1'b0;
      accepted_code  <= HALL_ILL0;
      accept_strobe  <= 1'b0;
      illegal_strobe <= 1'b0;
    end else begin
      sync1          <= hall;
      sync2          <= sync1;
      sync_d         <= sync2;
      accept_strobe  <= 1'b0;
      illegal_strobe <= 1'b0;
      if (sync2 == accepted_code) begin
        stab_cnt <= '0;
        held     <= 1'b0;
      end else begin
        stab_cnt <= cnt_next;
        if (restart) begin
          held <= 1'b0;
        end
        if (fire) begin
          if (is_illegal(sync2)) begin
            illegal_strobe <= 1'b1;
            held           <= 1'b1;
          end else begin
            accepted_code <= sync2;
            accept_strobe <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/hall_period_meter.sv
// Measures the electrical revolution period of a BLDC motor from its Hall
// sensors, in clk cycles per revolution (EDGES_PER_PERIOD accepted edges).
// Ports:
//   clk, reset    - clock, synchronous active-low reset
//   enable        - measurement enable; low forces IDLE
//   hall[2:0]     - raw Hall lines {C,B,A}
//   period_speed  - last completed period (all-ones after a stall)
//   period_valid  - one-cycle strobe for each new period_speed
//   direction     - 1 forward, 0 reverse
//   stalled       - period counter saturated before the window completed
//   hall_error    - sticky: illegal code or skipped step seen
module hall_period_meter
  import hall_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 16,
  parameter int unsigned DEBOUNCE_CYCLES  = 8,
  parameter int unsigned EDGES_PER_PERIOD = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [2:0]            hall,
  output logic [DATA_WIDTH-1:0] period_speed,
  output logic                  period_valid,
  output logic                  direction,
  output logic                  stalled,
  output logic                  hall_error
);

  localparam int unsigned EW = $clog2(EDGES_PER_PERIOD + 1);
  localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

  meter_state_t          state;
  logic [DATA_WIDTH-1:0] period_cnt;
  logic [EW-1:0]         edge_cnt;
  logic [2:0]            ref_code;
  logic                  ref_valid;

  logic [2:0] accepted_code;
  logic       accept_strobe;
  logic       illegal_strobe;

  logic is_fwd;
  logic is_rev;
  logic adj;
  logic error_ev;
  logic last_edge;
  logic sat;

  hall_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk           (clk),
    .reset         (reset),
    .hall          (hall),
    .accepted_code (accepted_code),
    .accept_strobe (accept_strobe),
    .illegal_strobe(illegal_strobe)
  );

  // Classify the accepted edge against the reference code.
  always_comb begin
    is_fwd    = accept_strobe && ref_valid && (accepted_code == fwd_next(ref_code));
    is_rev    = accept_strobe && ref_valid && (accepted_code == rev_next(ref_code));
    adj       = is_fwd || is_rev;
    error_ev  = illegal_strobe || (accept_strobe && ref_valid && !adj);
    last_edge = (edge_cnt == EW'(EDGES_PER_PERIOD - 1));
    sat       = (period_cnt == CNT_MAX - DATA_WIDTH'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      period_cnt   <= '0;
      edge_cnt     <= '0;
      ref_code     <= HALL_ILL0;
      ref_valid    <= 1'b0;
      period_speed <= '0;
      period_valid <= 1'b0;
      direction    <= 1'b0;
      stalled      <= 1'b0;
      hall_error   <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!enable) begin
        // Partial windows are dropped; the first code after enable has no predecessor.
        state      <= IDLE;
        period_cnt <= '0;
        edge_cnt   <= '0;
        ref_valid  <= 1'b0;
      end else begin
        if (accept_strobe) begin
          ref_code  <= accepted_code;
          ref_valid <= 1'b1;
        end
        case (state)
          IDLE: state <= ARM;

          ARM, STALL: begin
            if (error_ev) begin
              hall_error <= 1'b1;
              state      <= ARM;
            end else if (adj) begin
              period_cnt <= '0;
              edge_cnt   <= '0;
              direction  <= is_fwd;
              state      <= MEASURE;
            end
          end

          MEASURE: begin
            if (error_ev) begin
              hall_error <= 1'b1;
              period_cnt <= '0;
              edge_cnt   <= '0;
              state      <= ARM;
            end else if (adj && (is_fwd != direction)) begin
              // Reversal: discard the window and restart it from this edge.
              direction  <= is_fwd;
              period_cnt <= '0;
              edge_cnt   <= '0;
            end else if (adj && last_edge) begin
              // Completing edge beats saturation in the same cycle.
              period_speed <= period_cnt + DATA_WIDTH'(1);
              period_valid <= 1'b1;
              stalled      <= 1'b0;
              period_cnt   <= '0;
              edge_cnt     <= '0;
            end else begin
              if (adj) begin
                edge_cnt <= edge_cnt + EW'(1);
              end
              if (sat) begin
                period_cnt   <= CNT_MAX;
                period_speed <= CNT_MAX;
                period_valid <= 1'b1;
                stalled      <= 1'b1;
                state        <= STALL;
              end else begin
                period_cnt <= period_cnt + DATA_WIDTH'(1);
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hall_period_meter.sv
module tb_hall_period_meter;
  import hall_pkg::*;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [2:0]  hall;
  logic [15:0] period_speed;
  logic        period_valid;
  logic        direction;
  logic        stalled;
  logic        hall_error;

  int total = 0;
  int bad   = 0;
  int nvalid = 0;
  logic [15:0] last_period = '0;
  int pos = 0;
  logic [2:0] seq [0:5] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  hall_period_meter #(
    .DATA_WIDTH(16),
    .DEBOUNCE_CYCLES(8),
    .EDGES_PER_PERIOD(6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .hall        (hall),
    .period_speed(period_speed),
    .period_valid(period_valid),
    .direction   (direction),
    .stalled     (stalled),
    .hall_error  (hall_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (period_valid) begin
      nvalid++;
      last_period = period_speed;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step(input bit fwd);
    pos  = fwd ? (pos + 1) % 6 : (pos + 5) % 6;
    hall = seq[pos];
    cycles(200);
  endtask

  task automatic test_reset;
    reset = 1'b0; enable = 1'b0; hall = 3'b000;
    cycles(3);
    total++; if (period_speed !== 16'd0) begin bad++; $display("FAIL reset_period: got %0d want 0", period_speed); end
    total++; if (period_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", period_valid); end
    total++; if (direction !== 1'b0) begin bad++; $display("FAIL reset_dir: got %b want 0", direction); end
    total++; if (stalled !== 1'b0) begin bad++; $display("FAIL reset_stalled: got %b want 0", stalled); end
    total++; if (hall_error !== 1'b0) begin bad++; $display("FAIL reset_error: got %b want 0", hall_error); end
    reset = 1'b1;
    cycles(2);
  endtask

  task automatic test_accept_latency;
    int first;
    first  = -1;
    enable = 1'b1;
    pos    = 0;
    hall   = seq[0];
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (dut.u_deb.accept_strobe === 1'b1 && first < 0) first = i;
    end
    total++; if (first !== 10) begin bad++; $display("FAIL accept_latency: got %0d want 10", first); end
    total++; if (hall_error !== 1'b0) begin bad++; $display("FAIL first_code_error: got %b want 0", hall_error); end
    total++; if (nvalid !== 0) begin bad++; $display("FAIL first_code_valid: got %0d strobes want 0", nvalid); end
  endtask

  task automatic test_forward;
    int v0;
    v0 = nvalid;
    for (int i = 0; i < 7; i++) step(1'b1);
    total++; if (nvalid !== v0 + 1) begin bad++; $display("FAIL fwd_rev1_count: got %0d want %0d", nvalid, v0 + 1); end
    total++; if (last_period !== 16'd1200) begin bad++; $display("FAIL fwd_rev1_period: got %0d want 1200", last_period); end
    for (int i = 0; i < 6; i++) step(1'b1);
    total++; if (nvalid !== v0 + 2) begin bad++; $display("FAIL fwd_rev2_count: got %0d want %0d", nvalid, v0 + 2); end
    total++; if (last_period !== 16'd1200) begin bad++; $display("FAIL fwd_rev2_period: got %0d want 1200", last_period); end
    total++; if (direction !== 1'b1) begin bad++; $display("FAIL fwd_dir: got %b want 1", direction); end
  endtask

  task automatic test_glitch;
    int v0;
    v0 = nvalid;
    for (int i = 0; i < 6; i++) begin
      pos  = (pos + 1) % 6;
      hall = seq[pos];
      cycles(100);
      hall = (i % 2 == 0) ? 3'b111 : seq[(pos + 3) % 6];
      cycles(3);
      hall = seq[pos];
      cycles(97);
    end
    total++; if (hall_error !== 1'b0) begin bad++; $display("FAIL glitch_error: got %b want 0", hall_error); end
    total++; if (nvalid !== v0 + 1) begin bad++; $display("FAIL glitch_count: got %0d want %0d", nvalid, v0 + 1); end
    total++; if (last_period !== 16'd1200) begin bad++; $display("FAIL glitch_period: got %0d want 1200", last_period); end
  endtask

  task automatic test_illegal_skip;
    int v0;
    v0 = nvalid;
    hall = 3'b111;
    cycles(20);
    hall = seq[pos];
    cycles(200);
    total++; if (hall_error !== 1'b1) begin bad++; $display("FAIL illegal_error: got %b want 1", hall_error); end
    total++; if (dut.state !== ARM) begin bad++; $display("FAIL illegal_state: got %0d want %0d", dut.state, ARM); end
    pos  = (pos + 2) % 6;
    hall = seq[pos];
    cycles(200);
    total++; if (hall_error !== 1'b1) begin bad++; $display("FAIL skip_error: got %b want 1", hall_error); end
    total++; if (dut.state !== ARM) begin bad++; $display("FAIL skip_state: got %0d want %0d", dut.state, ARM); end
    total++; if (nvalid !== v0) begin bad++; $display("FAIL discard_count: got %0d want %0d", nvalid, v0); end
    for (int i = 0; i < 7; i++) step(1'b1);
    total++; if (nvalid !== v0 + 1) begin bad++; $display("FAIL post_error_count: got %0d want %0d", nvalid, v0 + 1); end
    total++; if (last_period !== 16'd1200) begin bad++; $display("FAIL post_error_period: got %0d want 1200", last_period); end
  endtask

  task automatic test_stall;
    int v0;
    v0 = nvalid;
    cycles(66000);
    total++; if (nvalid !== v0 + 1) begin bad++; $display("FAIL stall_count: got %0d want %0d", nvalid, v0 + 1); end
    total++; if (last_period !== 16'hFFFF) begin bad++; $display("FAIL stall_period: got %h want ffff", last_period); end
    total++; if (stalled !== 1'b1) begin bad++; $display("FAIL stall_flag: got %b want 1", stalled); end
    step(1'b1);
    total++; if (stalled !== 1'b1) begin bad++; $display("FAIL stall_hold: got %b want 1", stalled); end
    for (int i = 0; i < 6; i++) step(1'b1);
    total++; if (nvalid !== v0 + 2) begin bad++; $display("FAIL resume_count: got %0d want %0d", nvalid, v0 + 2); end
    total++; if (last_period !== 16'd1200) begin bad++; $display("FAIL resume_period: got %0d want 1200", last_period); end
    total++; if (stalled !== 1'b0) begin bad++; $display("FAIL resume_stalled: got %b want 0", stalled); end
  endtask

  task automatic test_reverse_enable;
    int v0;
    v0 = nvalid;
    for (int i = 0; i < 7; i++) step(1'b0);
    total++; if (nvalid !== v0 + 1) begin bad++; $display("FAIL rev_count: got %0d want %0d", nvalid, v0 + 1); end
    total++; if (last_period !== 16'd1200) begin bad++; $display("FAIL rev_period: got %0d want 1200", last_period); end
    total++; if (direction !== 1'b0) begin bad++; $display("FAIL rev_dir: got %b want 0", direction); end
    step(1'b0);
    step(1'b0);
    step(1'b1);
    total++; if (nvalid !== v0 + 1) begin bad++; $display("FAIL reversal_count: got %0d want %0d", nvalid, v0 + 1); end
    total++; if (direction !== 1'b1) begin bad++; $display("FAIL reversal_dir: got %b want 1", direction); end
    for (int i = 0; i < 6; i++) step(1'b1);
    total++; if (nvalid !== v0 + 2) begin bad++; $display("FAIL restart_count: got %0d want %0d", nvalid, v0 + 2); end
    total++; if (last_period !== 16'd1200) begin bad++; $display("FAIL restart_period: got %0d want 1200", last_period); end
    for (int i = 0; i < 3; i++) step(1'b1);
    enable = 1'b0;
    cycles(50);
    total++; if (nvalid !== v0 + 2) begin bad++; $display("FAIL disable_count: got %0d want %0d", nvalid, v0 + 2); end
    total++; if (period_speed !== 16'd1200) begin bad++; $display("FAIL disable_hold: got %0d want 1200", period_speed); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL disable_state: got %0d want %0d", dut.state, IDLE); end
    total++; if (hall_error !== 1'b1) begin bad++; $display("FAIL sticky_error: got %b want 1", hall_error); end
  endtask

  initial begin
    test_reset();
    test_accept_latency();
    test_forward();
    test_glitch();
    test_illegal_skip();
    test_stall();
    test_reverse_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
